branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl_if.sv | 60 ++++++
 rtl/branch_ctrl.sv | 137 +++++++++++++
 tb/tb_branch_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_ctrl_if.sv
// Branch controller bus bundle.
// Groups the fetch-side prediction lookup, the EX-stage resolve inputs, the
// redirect handshake, the flush output and the statistics counters.
//   slave  : the branch controller side
//   master : the pipeline / environment side
//   if_pc, pred_taken          : fetch PC and its BHT prediction
//   ex_valid .. ex_target      : EX-stage branch information
//   redirect_valid/_pc/_ready  : redirect handshake toward fetch
//   flush                      : kill IF/ID and ID/EX contents
//   br_count, mis_count        : resolved / mispredicted branch counters
interface branch_ctrl_if;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic        ex_branch;
    logic        ex_taken;
    logic [31:0] ex_pc;
    logic        ex_pred;
    logic [31:0] ex_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        flush;
    logic [15:0] br_count;
    logic [15:0] mis_count;

    modport slave (
        input  if_pc,
        output pred_taken,
        input  ex_valid,
        input  ex_branch,
        input  ex_taken,
        input  ex_pc,
        input  ex_pred,
        input  ex_target,
        output redirect_valid,
        output redirect_pc,
        input  redirect_ready,
        output flush,
        output br_count,
        output mis_count
    );

    modport master (
        output if_pc,
        input  pred_taken,
        output ex_valid,
        output ex_branch,
        output ex_taken,
        output ex_pc,
        output ex_pred,
        output ex_target,
        input  redirect_valid,
        input  redirect_pc,
        output redirect_ready,
        input  flush,
        input  br_count,
        input  mis_count
    );
endinterface

// File: rtl/branch_ctrl.sv
// Branch controller: 16-entry BHT of 2-bit saturating counters, misprediction
// detection, redirect/flush generation with a ready handshake, and saturating
// branch / misprediction counters.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : branch_ctrl_if.slave bundle (fetch lookup, EX resolve, redirect, counters)
module branch_ctrl (
    input  logic         clk,
    input  logic         rst,
    branch_ctrl_if.slave bus
);

    typedef enum logic [0:0] {StRun, StHold} state_e;

    state_e      state_q, state_d;
    logic [1:0]  bht_q [16];
    logic [1:0]  bht_upd;
    logic [15:0] br_count_q, br_count_d;
    logic [15:0] mis_count_q, mis_count_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        resolve;
    logic        mispredict;
    logic [31:0] correct_pc;
    logic [3:0]  upd_idx;
    logic        redirect_valid;
    logic        flush;
    logic [31:0] redirect_pc;

    // Only PC[5:2] index the table; the rest of the fetch PC is don't-care.
    logic unused_if_pc_bits;
    assign unused_if_pc_bits = ^{bus.if_pc[31:6], bus.if_pc[1:0]};

    assign upd_idx    = bus.ex_pc[5:2];
    assign resolve    = bus.ex_valid & bus.ex_branch & (state_q == StRun);
    assign mispredict = resolve & (bus.ex_taken != bus.ex_pred);
    assign correct_pc = bus.ex_taken ? bus.ex_target : (bus.ex_pc + 32'd4);

    // Read straight from the registered table: a same-cycle update is only
    // visible from the next cycle on.
    assign bus.pred_taken = bht_q[bus.if_pc[5:2]][1];

    // Saturating counter step for the entry being resolved.
    always_comb begin
        bht_upd = bht_q[upd_idx];
        if (bus.ex_taken) begin
            if (bht_q[upd_idx] != 2'd3) begin
                bht_upd = bht_q[upd_idx] + 2'd1;
            end
        end else begin
            if (bht_q[upd_idx] != 2'd0) begin
                bht_upd = bht_q[upd_idx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                bht_q[i] <= 2'd1;
            end
        end else if (resolve) begin
            bht_q[upd_idx] <= bht_upd;
        end
    end

    always_comb begin
        br_count_d  = br_count_q;
        mis_count_d = mis_count_q;
        if (resolve && (br_count_q != 16'hFFFF)) begin
            br_count_d = br_count_q + 16'd1;
        end
        if (mispredict && (mis_count_q != 16'hFFFF)) begin
            mis_count_d = mis_count_q + 16'd1;
        end
    end

    // Redirect FSM: RUN redirects combinationally; HOLD replays the latched
    // target until fetch accepts it.
    always_comb begin
        state_d        = state_q;
        redirect_pc_d  = redirect_pc_q;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        redirect_pc    = 32'd0;
        unique case (state_q)
            StRun: begin
                if (mispredict) begin
                    redirect_valid = 1'b1;
                    flush          = 1'b1;
                    redirect_pc    = correct_pc;
                    if (!bus.redirect_ready) begin
                        state_d       = StHold;
                        redirect_pc_d = correct_pc;
                    end
                end
            end
            StHold: begin
                redirect_valid = 1'b1;
                flush          = 1'b1;
                redirect_pc    = redirect_pc_q;
                if (bus.redirect_ready) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
        // Nothing may leak out while reset is asserted.
        if (rst) begin
            redirect_valid = 1'b0;
            flush          = 1'b0;
            redirect_pc    = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            br_count_q    <= 16'd0;
            mis_count_q   <= 16'd0;
            redirect_pc_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            br_count_q    <= br_count_d;
            mis_count_q   <= mis_count_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign bus.redirect_valid = redirect_valid;
    assign bus.flush          = flush;
    assign bus.redirect_pc    = redirect_pc;
    assign bus.br_count       = br_count_q;
    assign bus.mis_count      = mis_count_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: a table of single-cycle vectors followed by
// hand-written multi-cycle sequences (HOLD, BHT saturation, reset in HOLD,
// counter saturation).
module tb_branch_ctrl;

    logic clk;
    logic rst;

    branch_ctrl_if bus ();

    branch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic        ex_valid;
        logic        ex_branch;
        logic        ex_taken;
        logic        ex_pred;
        logic        ready;
        logic [31:0] ex_pc;
        logic [31:0] ex_target;
        logic [31:0] if_pc;
        logic        exp_pred;
        logic        exp_rv;
        logic [31:0] exp_rpc;
        logic [15:0] exp_br;
        logic [15:0] exp_mis;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(input logic v, input logic b, input logic t, input logic p,
                                input logic rdy, input logic [31:0] pc, input logic [31:0] tgt,
                                input logic [31:0] ipc, input logic e_pred, input logic e_rv,
                                input logic [31:0] e_rpc, input logic [15:0] e_br,
                                input logic [15:0] e_mis);
        vec_t r;
        r.ex_valid  = v;
        r.ex_branch = b;
        r.ex_taken  = t;
        r.ex_pred   = p;
        r.ready     = rdy;
        r.ex_pc     = pc;
        r.ex_target = tgt;
        r.if_pc     = ipc;
        r.exp_pred  = e_pred;
        r.exp_rv    = e_rv;
        r.exp_rpc   = e_rpc;
        r.exp_br    = e_br;
        r.exp_mis   = e_mis;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic t, input logic p,
                         input logic rdy, input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [31:0] ipc);
        bus.ex_valid       = v;
        bus.ex_branch      = b;
        bus.ex_taken       = t;
        bus.ex_pred        = p;
        bus.redirect_ready = rdy;
        bus.ex_pc          = pc;
        bus.ex_target      = tgt;
        bus.if_pc          = ipc;
    endtask

    task automatic idle(input logic [31:0] ipc);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0, ipc);
    endtask

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic e_rv, input logic [31:0] e_rpc,
                           input logic [15:0] e_br, input logic [15:0] e_mis);
        chk({name, ".redirect_valid"}, {31'd0, bus.redirect_valid}, {31'd0, e_rv});
        chk({name, ".flush"}, {31'd0, bus.flush}, {31'd0, e_rv});
        chk({name, ".redirect_pc"}, bus.redirect_pc, e_rpc);
        chk({name, ".br_count"}, {16'd0, bus.br_count}, {16'd0, e_br});
        chk({name, ".mis_count"}, {16'd0, bus.mis_count}, {16'd0, e_mis});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        tbl[0]  = mk(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 16'd0, 16'd0);
        tbl[1]  = mk(1, 1, 1, 0, 1, 32'h100, 32'h200, 32'h100, 0, 1, 32'h200, 16'd0, 16'd0);
        tbl[2]  = mk(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h100, 1, 0, 32'h0, 16'd1, 16'd1);
        tbl[3]  = mk(1, 0, 0, 1, 1, 32'h100, 32'h300, 32'h100, 1, 0, 32'h0, 16'd1, 16'd1);
        tbl[4]  = mk(0, 1, 0, 1, 1, 32'h100, 32'h300, 32'h100, 1, 0, 32'h0, 16'd1, 16'd1);
        tbl[5]  = mk(1, 1, 1, 1, 1, 32'h48, 32'hFFFFFFFC, 32'h8, 0, 0, 32'h0, 16'd1, 16'd1);
        tbl[6]  = mk(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h8, 1, 0, 32'h0, 16'd2, 16'd1);
        tbl[7]  = mk(1, 1, 0, 1, 1, 32'hFFFFFFFC, 32'h500, 32'h3C, 0, 1, 32'h0, 16'd2, 16'd1);
        tbl[8]  = mk(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h3C, 0, 0, 32'h0, 16'd3, 16'd2);
        tbl[9]  = mk(1, 1, 1, 0, 1, 32'h3C, 32'h12345678, 32'h0, 1, 1, 32'h12345678,
                     16'd3, 16'd2);
        tbl[10] = mk(0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h3C, 0, 0, 32'h0, 16'd4, 16'd3);

        do_reset();

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].ex_valid, tbl[i].ex_branch, tbl[i].ex_taken, tbl[i].ex_pred,
                  tbl[i].ready, tbl[i].ex_pc, tbl[i].ex_target, tbl[i].if_pc);
            @(negedge clk);
            chk($sformatf("vec%0d.pred_taken", i), {31'd0, bus.pred_taken},
                {31'd0, tbl[i].exp_pred});
            chk_out($sformatf("vec%0d", i), tbl[i].exp_rv, tbl[i].exp_rpc, tbl[i].exp_br,
                    tbl[i].exp_mis);
            next_cycle();
        end

        // Mispredict with fetch stalled: redirect held 4 cycles, EX ignored in HOLD.
        drive(1, 1, 0, 1, 0, 32'h104, 32'hDEAD, 32'h0);
        @(negedge clk);
        chk_out("hold.c0", 1, 32'h108, 16'd4, 16'd3);
        next_cycle();
        for (int c = 1; c < 4; c++) begin
            drive(1, 1, 1, 0, (c == 3), 32'h3C, 32'h999, 32'h0);
            @(negedge clk);
            chk_out($sformatf("hold.c%0d", c), 1, 32'h108, 16'd5, 16'd4);
            next_cycle();
        end
        idle(32'h104);
        @(negedge clk);
        chk_out("hold.done", 0, 32'h0, 16'd5, 16'd4);
        chk("hold.bht1_pred", {31'd0, bus.pred_taken}, 32'd0);
        chk("hold.bht15_untouched", {30'd0, dut.bht_q[15]}, 32'd1);
        next_cycle();

        // Four taken resolves at index 5: counter 1,2,3,3 before each.
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 1, 1, 1, 32'h14, 32'h40, 32'h0);
            @(negedge clk);
            chk($sformatf("sat.bht5_step%0d", k), {30'd0, dut.bht_q[5]},
                (k == 0) ? 32'd1 : ((k == 1) ? 32'd2 : 32'd3));
            next_cycle();
        end
        idle(32'h14);
        @(negedge clk);
        chk("sat.bht5_final", {30'd0, dut.bht_q[5]}, 32'd3);
        chk("sat.pred_0x14", {31'd0, bus.pred_taken}, 32'd1);
        chk_out("sat.counts", 0, 32'h0, 16'd9, 16'd4);
        next_cycle();

        // Reset while in HOLD.
        drive(1, 1, 0, 1, 0, 32'h14, 32'h40, 32'h0);
        @(negedge clk);
        chk_out("rsthold.enter", 1, 32'h18, 16'd9, 16'd4);
        next_cycle();
        rst = 1'b1;
        drive(1, 1, 1, 0, 0, 32'h20, 32'h700, 32'h0);
        @(negedge clk);
        chk("rsthold.rv_in_rst", {31'd0, bus.redirect_valid}, 32'd0);
        chk("rsthold.flush_in_rst", {31'd0, bus.flush}, 32'd0);
        next_cycle();
        rst = 1'b0;
        idle(32'h0);
        @(negedge clk);
        chk_out("rsthold.after", 0, 32'h0, 16'd0, 16'd0);
        next_cycle();
        for (int j = 0; j < 16; j++) begin
            idle(32'(j) << 2);
            @(negedge clk);
            chk($sformatf("rst.pred_idx%0d", j), {31'd0, bus.pred_taken}, 32'd0);
            next_cycle();
        end
        // RUN again: the redirect is the live target, not the stale latched one.
        drive(1, 1, 1, 0, 1, 32'h20, 32'h700, 32'h0);
        @(negedge clk);
        chk_out("rsthold.run", 1, 32'h700, 16'd0, 16'd0);
        next_cycle();

        // br_count saturation.
        do_reset();
        drive(1, 1, 0, 0, 1, 32'h0, 32'h0, 32'h0);
        repeat (65535) @(posedge clk);
        #1;
        @(negedge clk);
        chk_out("brsat.full", 0, 32'h0, 16'hFFFF, 16'd0);
        next_cycle();
        @(negedge clk);
        chk_out("brsat.stay", 0, 32'h0, 16'hFFFF, 16'd0);
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
